// File: rtl/alu_defs_pkg.sv
// Shared execute-stage definitions: M-extension opcodes, FSM states and the
// fixed results used for divide special cases.
package alu_defs_pkg;

    localparam int XLEN = 32;

    // M-extension SELECT encodings, shared with the ALU and the control unit
    localparam logic [4:0] SEL_MUL    = 5'b01000;
    localparam logic [4:0] SEL_MULH   = 5'b01001;
    localparam logic [4:0] SEL_MULHU  = 5'b01010;
    localparam logic [4:0] SEL_MULHSU = 5'b01011;
    localparam logic [4:0] SEL_DIV    = 5'b01100;
    localparam logic [4:0] SEL_DIVU   = 5'b01101;
    localparam logic [4:0] SEL_REM    = 5'b01110;
    localparam logic [4:0] SEL_REMU   = 5'b01111;

    // Quotient for a zero divisor, and the most negative signed value
    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    // All eight multiply/divide opcodes share the 01xxx prefix
    function automatic logic is_muldiv_op(input logic [4:0] sel);
        return sel[4:3] == 2'b01;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes. The FSM feeds the
// registered partial remainder/quotient back through this block each cycle.
module div_step
    import alu_defs_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] rem_shift;
    logic          fits;

    // Shift {rem, quo} left, trial-subtract, keep the difference if it fits.
    // The 32-bit subtraction is exact whenever it fits, since the result is
    // then smaller than the divisor.
    always_comb begin
        rem_shift = {rem, quo[XLEN-1]};
        fits      = rem_shift >= {1'b0, divisor};
        rem_next  = fits ? (rem_shift[XLEN-1:0] - divisor) : rem_shift[XLEN-1:0];
        quo_next  = {quo[XLEN-2:0], fits};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Multiplies and divide special cases
// finish one cycle after acceptance; other divides run 32 restoring steps
// followed by a sign-fixup cycle.
module muldiv_unit
    import alu_defs_pkg::*;
(
    input  logic            CLK,
    input  logic            RESETN,
    input  logic            START,
    input  logic            KILL,
    input  logic [4:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic [XLEN-1:0] RESULT,
    output logic            BUSY,
    output logic            DONE
);

    state_t          state_reg, state_next;
    logic [XLEN-1:0] rem_reg, quo_reg, dvsr_reg, result_reg;
    logic [4:0]      cnt_reg;
    logic            neg_q_reg, neg_r_reg, is_rem_reg;
    logic            busy_reg, done_reg;

    // Acceptance and operation decode
    logic accept, is_div, is_signed_div, sel_rem, div_by_zero, div_ovf, fast_op;
    assign accept        = (state_reg == ST_IDLE || state_reg == ST_DONE) && START && !KILL
                           && is_muldiv_op(SELECT);
    assign is_div        = SELECT[2];
    assign is_signed_div = ~SELECT[0];
    assign sel_rem       = SELECT[1];
    assign div_by_zero   = DATA2 == '0;
    assign div_ovf       = is_signed_div && DATA1 == INT_MIN && DATA2 == '1;
    assign fast_op       = !is_div || div_by_zero || div_ovf;

    // Single signed multiplier; the 33rd bit selects sign or zero extension
    logic               a_sgn, b_sgn;
    logic signed [32:0] mul_a, mul_b;
    logic signed [63:0] mul_full;
    logic [XLEN-1:0]    mul_res, spec_res, fast_res;
    assign a_sgn    = SELECT[0];                 // MULH, MULHSU
    assign b_sgn    = SELECT[1:0] == 2'b01;      // MULH only
    assign mul_a    = {a_sgn & DATA1[XLEN-1], DATA1};
    assign mul_b    = {b_sgn & DATA2[XLEN-1], DATA2};
    assign mul_full = mul_a * mul_b;
    assign mul_res  = (SELECT[1:0] == 2'b00) ? mul_full[31:0] : mul_full[63:32];
    assign spec_res = div_by_zero ? (sel_rem ? DATA1 : DIV0_QUOT)
                                  : (sel_rem ? '0 : INT_MIN);
    assign fast_res = is_div ? spec_res : mul_res;

    // Operand magnitudes and result signs for the iterative path
    logic            sign1, sign2;
    logic [XLEN-1:0] abs1, abs2, step_rem, step_quo, fix_q, fix_r;
    assign sign1 = is_signed_div & DATA1[XLEN-1];
    assign sign2 = is_signed_div & DATA2[XLEN-1];
    assign abs1  = sign1 ? -DATA1 : DATA1;
    assign abs2  = sign2 ? -DATA2 : DATA2;
    assign fix_q = neg_q_reg ? -quo_reg : quo_reg;
    assign fix_r = neg_r_reg ? -rem_reg : rem_reg;

    div_step u_div_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (dvsr_reg),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Next-state logic: KILL aborts an iterating divide without a DONE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept)
                    state_next = fast_op ? ST_DONE : ST_DIV;
                else
                    state_next = ST_IDLE;
            end
            ST_DIV: begin
                if (KILL)
                    state_next = ST_IDLE;
                else if (cnt_reg == 5'd31)
                    state_next = ST_FIX;
            end
            ST_FIX:  state_next = KILL ? ST_IDLE : ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register with registered BUSY/DONE derived from the next state
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == ST_DIV) || (state_next == ST_FIX);
            done_reg  <= state_next == ST_DONE;
        end
    end

    // Datapath: capture at acceptance, iterate in DIV, sign-fix in FIX
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvsr_reg   <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            is_rem_reg <= 1'b0;
        end else if (accept) begin
            if (fast_op) begin
                result_reg <= fast_res;
            end else begin
                rem_reg    <= '0;
                quo_reg    <= abs1;
                dvsr_reg   <= abs2;
                neg_q_reg  <= sign1 ^ sign2;
                neg_r_reg  <= sign1;
                is_rem_reg <= sel_rem;
                cnt_reg    <= '0;
            end
        end else if (state_reg == ST_DIV && !KILL) begin
            rem_reg <= step_rem;
            quo_reg <= step_quo;
            cnt_reg <= cnt_reg + 5'd1;
        end else if (state_reg == ST_FIX && !KILL) begin
            result_reg <= is_rem_reg ? fix_r : fix_q;
        end
    end

    assign RESULT = result_reg;
    assign BUSY   = busy_reg;
    assign DONE   = done_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results come from a plain
// arithmetic model of RV32M semantics; a monitor checks each DONE pulse.
module tb_muldiv_unit;
    import alu_defs_pkg::*;

    logic        CLK = 1'b0;
    logic        RESETN, START, KILL;
    logic [4:0]  SELECT;
    logic [31:0] DATA1, DATA2, RESULT;
    logic        BUSY, DONE;

    muldiv_unit dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .START  (START),
        .KILL   (KILL),
        .SELECT (SELECT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .RESULT (RESULT),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    initial forever #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          exp_busy = 0;
    logic [31:0] last_res = 32'h0;

    function automatic string op_name(input logic [4:0] sel);
        case (sel)
            SEL_MUL:    return "MUL";
            SEL_MULH:   return "MULH";
            SEL_MULHU:  return "MULHU";
            SEL_MULHSU: return "MULHSU";
            SEL_DIV:    return "DIV";
            SEL_DIVU:   return "DIVU";
            SEL_REM:    return "REM";
            SEL_REMU:   return "REMU";
            default:    return "NOP";
        endcase
    endfunction

    // Reference: 64-bit integer arithmetic with RV32M corner-case rules
    function automatic logic [31:0] model_res(input logic [4:0] sel,
                                              input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb2, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (sel)
            SEL_MUL:    begin p = sa * sb2; return p[31:0];  end
            SEL_MULH:   begin p = sa * sb2; return p[63:32]; end
            SEL_MULHU:  begin p = ua * ub;  return p[63:32]; end
            SEL_MULHSU: begin p = sa * ub;  return p[63:32]; end
            SEL_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                p = sa / sb2; return p[31:0];
            end
            SEL_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            SEL_REM: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = sa % sb2; return p[31:0];
            end
            SEL_REMU: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] sel, input logic [31:0] a,
                                     input logic [31:0] b);
        if (sel == SEL_MUL || sel == SEL_MULH || sel == SEL_MULHU || sel == SEL_MULHSU) return 1;
        if (b == 0) return 1;
        if ((sel == SEL_DIV || sel == SEL_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return 34;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESETN && DONE) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: DONE=1 RESULT=%h, required no DONE", RESULT);
                end else begin
                    e = sb.pop_front();
                    check({e.name, " result"}, RESULT, e.res);
                    check({e.name, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
                    $display("%s done: result %h latency %0d", e.name, RESULT, cyc - e.acc + 1);
                end
            end
        end
    endtask

    // Drive a request in the current (negedge) slot; optionally expect a response
    task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_it);
        exp_t e;
        SELECT = sel;
        DATA1  = a;
        DATA2  = b;
        START  = 1'b1;
        if (expect_it) begin
            e.res  = model_res(sel, a, b);
            e.acc  = cyc + 1;
            e.lat  = model_lat(sel, a, b);
            e.name = $sformatf("%s %h,%h", op_name(sel), a, b);
            sb.push_back(e);
            last_res = e.res;
            exp_busy = (e.lat == 34) ? 33 : 0;
        end
    endtask

    // Wait for the DONE cycle (bounded), counting BUSY cycles on the way
    task automatic wait_done(input string nm, input bit check_busy);
        int  bcnt = 0;
        bit  seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge CLK);
            START = 1'b0;
            if (BUSY) bcnt++;
            if (DONE) seen = 1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: no DONE within 100 cycles, required DONE", nm);
        end else if (check_busy) begin
            check({nm, " busy_cycles"}, 32'(bcnt), 32'(exp_busy));
        end
    endtask

    task automatic no_done_window(input string nm, input int n);
        int dcnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            START = 1'b0;
            if (DONE) dcnt++;
        end
        check({nm, " done_count"}, 32'(dcnt), 32'h0);
    endtask

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t dir[12] = '{
        '{SEL_MUL,    32'h0000_0007, 32'hFFFF_FFFD},
        '{SEL_MULH,   32'h8000_0000, 32'h8000_0000},
        '{SEL_MULHU,  32'h8000_0000, 32'h8000_0000},
        '{SEL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{SEL_DIV,    32'hFFFF_FFEC, 32'h0000_0006},
        '{SEL_REM,    32'hFFFF_FFEC, 32'h0000_0006},
        '{SEL_DIVU,   32'hFFFF_FFFF, 32'h0000_0010},
        '{SEL_REMU,   32'hFFFF_FFFF, 32'h0000_0010},
        '{SEL_DIVU,   32'h0000_0005, 32'h0000_0000},
        '{SEL_REMU,   32'h0000_0005, 32'h0000_0000},
        '{SEL_DIV,    32'h8000_0000, 32'hFFFF_FFFF},
        '{SEL_REM,    32'h8000_0000, 32'hFFFF_FFFF}
    };

    initial begin
        logic [4:0]  rs;
        logic [31:0] ra, rb;
        int          r;

        RESETN = 1'b0; START = 1'b0; KILL = 1'b0;
        SELECT = 5'b0; DATA1 = 32'h0; DATA2 = 32'h0;
        repeat (3) @(negedge CLK);
        check("reset RESULT", RESULT, 32'h0);
        check("reset BUSY", 32'(BUSY), 32'h0);
        check("reset DONE", 32'(DONE), 32'h0);
        RESETN = 1'b1;
        fork monitor_loop(); join_none
        @(negedge CLK);

        // Directed vectors; each issues in the DONE cycle of the previous one
        foreach (dir[i]) begin
            issue(dir[i].sel, dir[i].a, dir[i].b, 1);
            wait_done(op_name(dir[i].sel), 1);
        end
        @(negedge CLK);
        check("done one-cycle pulse", 32'(DONE), 32'h0);

        // START with new operands during BUSY must be ignored
        issue(SEL_DIV, 32'hFFFF_FFEC, 32'h0000_0006, 1);
        repeat (5) begin @(negedge CLK); START = 1'b0; end
        issue(SEL_MUL, 32'h1234_5678, 32'h0000_0003, 0);
        wait_done("start_during_busy", 0);
        @(negedge CLK);

        // KILL mid-divide: BUSY drops next edge, no DONE, RESULT unchanged
        issue(SEL_DIVU, 32'hDEAD_BEEF, 32'h0000_0123, 0);
        repeat (10) begin @(negedge CLK); START = 1'b0; end
        check("kill busy_before", 32'(BUSY), 32'h1);
        KILL = 1'b1;
        @(negedge CLK);
        KILL = 1'b0;
        check("kill busy_after", 32'(BUSY), 32'h0);
        check("kill result_held", RESULT, last_res);
        no_done_window("kill", 40);

        // Non-M opcode with START produces no response
        issue(5'b00000, 32'h5, 32'h6, 0);
        @(negedge CLK);
        START = 1'b0;
        check("nop busy", 32'(BUSY), 32'h0);
        no_done_window("nop", 5);

        // Asynchronous reset mid-divide clears outputs immediately
        issue(SEL_DIV, 32'h7654_3210, 32'h0000_0007, 1);
        repeat (15) begin @(negedge CLK); START = 1'b0; end
        #2 RESETN = 1'b0;
        #1;
        check("async_reset RESULT", RESULT, 32'h0);
        check("async_reset BUSY", 32'(BUSY), 32'h0);
        check("async_reset DONE", 32'(DONE), 32'h0);
        sb.delete();
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        last_res = 32'h0;
        no_done_window("after_reset", 40);
        issue(SEL_MUL, 32'h3, 32'h4, 1);
        wait_done("mul_after_reset", 1);

        // Randomized operations, biased toward divide corner cases
        for (int i = 0; i < 150; i++) begin
            rs = 5'b01000 | 5'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0) rb = 32'h0;
            if (r == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (r == 2) rb = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0) repeat (2) @(negedge CLK);
            issue(rs, ra, rb, 1);
            wait_done(op_name(rs), 1);
        end

        repeat (3) @(negedge CLK);
        check("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
